// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of a selected, synchronised test clock over a fixed gate window.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       sig_in,
  input  logic [2:0]       sel,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;
  localparam int TW = $clog2(GATE_CYCLES + 4);
  state_t state, nxt;
  logic [2:0] sel_q;
  logic [7:0] sig_x;
  logic sync1, sync2, prev, rise, latch, t_end, ovf, ovf_q;
  logic [TW-1:0] t;
  logic [CNT_W-1:0] cnt, res;
  assign sig_x = {3'b000, sig_in};
  assign rise = sync2 & ~prev;
  assign t_end = (state == SETTLE) ? (t == TW'(2)) : (t == TW'(GATE_CYCLES - 1));
  assign valid = state == DONE;
  assign busy = state != IDLE;
  // the result is visible combinationally in DONE so it lines up with valid
  assign freq_out = valid ? cnt : res;
  assign overflow = valid ? ovf : ovf_q;
  always_comb begin
    nxt = state;
    latch = 1'b0;
    case (state)
      IDLE: if (start | cont) begin nxt = SETTLE; latch = 1'b1; end
      SETTLE: if (t_end) nxt = GATE;
      GATE: if (t_end) nxt = DONE;
      default: begin nxt = cont ? SETTLE : IDLE; latch = cont; end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= '0;
      {sync1, sync2, prev} <= '0;
      t <= '0;
      cnt <= '0;
      res <= '0;
      ovf <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= nxt;
      sync1 <= sig_x[sel_q];
      sync2 <= sync1;
      prev <= sync2;
      if (latch) sel_q <= sel;
      t <= (nxt != state || state == IDLE) ? '0 : t + 1'b1;
      if (state == DONE) begin
        res <= cnt;
        ovf_q <= ovf;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (state == GATE && rise) begin
        if (&cnt) ovf <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_freq_gate_counter.sv
// tb_freq_gate_counter: directed checks of the gated frequency counter with an on-bench divider chain.
module tb_freq_gate_counter;
  localparam int G = 1000;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [4:0] div = '0, sig_in;
  logic [2:0] sel = '0, sel8 = '0;
  logic start = 1'b0, cont = 1'b0, start8 = 1'b0;
  logic [19:0] freq_out;
  logic valid, overflow, busy;
  logic [7:0] freq8;
  logic valid8, ovf8, busy8;
  int checks = 0, errors = 0;
  int n, f, nv, nb;
  logic o;
  always #500 clk = ~clk;
  // divider: bit i toggles every 2^i clocks, so bit 0 is 500 kHz at 1 MHz clk
  always @(negedge clk) div <= div + 1'b1;
  assign sig_in = div;
  freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sel(sel), .start(start), .cont(cont),
    .freq_out(freq_out), .valid(valid), .overflow(overflow), .busy(busy));
  freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .sel(sel8), .start(start8), .cont(1'b0),
    .freq_out(freq8), .valid(valid8), .overflow(ovf8), .busy(busy8));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input int from, output int cnt);
    cnt = from;
    do begin tick(); cnt++; end while (!valid && cnt < 3000);
    chk("valid_timeout", cnt < 3000, 1);
  endtask
  task automatic run(input logic [2:0] s, output int cnt, output int fo, output logic ov);
    sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(1, cnt);
    fo = freq_out;
    ov = overflow;
    tick();
    chk("valid_drop", valid, 0);
    chk("idle_after", busy, 0);
  endtask
  task automatic run8(input logic [2:0] s, output int cnt, output int fo, output logic ov);
    sel8 = s;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cnt = 1;
    do begin tick(); cnt++; end while (!valid8 && cnt < 3000);
    chk("valid8_timeout", cnt < 3000, 1);
    fo = freq8;
    ov = ovf8;
    tick();
    chk("idle8_after", busy8, 0);
  endtask
  initial begin
    #100 rst_n = 1'b0;
    tick();
    chk("rst_freq", freq_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    run(3'd0, n, f, o);
    chk("sel0_lat", n, G + 4);
    chk("sel0_freq", f, 500);
    chk("sel0_ovf", o, 0);
    run(3'd4, n, f, o);
    chk("sel4_freq", (f == 31 || f == 32), 1);
    run(3'd2, n, f, o);
    chk("sel2_freq", f, 125);
    // continuous mode with a select change during the first window
    sel = 3'd1;
    cont = 1'b1;
    tick();
    repeat (500) tick();
    sel = 3'd3;
    wait_valid(501, n);
    chk("cont1_lat", n, G + 4);
    chk("cont1_freq", freq_out, 250);
    repeat (100) tick();
    cont = 1'b0;
    wait_valid(100, n);
    chk("cont_period", n, G + 4);
    chk("cont2_freq", (freq_out == 62 || freq_out == 63), 1);
    tick();
    chk("cont_stop_idle", busy, 0);
    // constant-zero channel, with a start pulse while busy
    sel = 3'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (200) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(202, n);
    chk("sel6_lat", n, G + 4);
    chk("sel6_freq", freq_out, 0);
    nv = 0;
    repeat (1100) begin tick(); if (valid) nv++; end
    chk("busy_start_ignored", nv, 0);
    chk("sel6_idle", busy, 0);
    run8(3'd0, n, f, o);
    chk("sat_lat", n, G + 4);
    chk("sat_freq", f, 255);
    chk("sat_ovf", o, 1);
    run8(3'd4, n, f, o);
    chk("sat_next_freq", (f == 31 || f == 32), 1);
    chk("sat_next_ovf", o, 0);
    run(3'd2, n, f, o);
    chk("pre_rst_freq", f, 125);
    // reset in the middle of a gate window
    sel = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (500) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_freq", freq_out, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_freq8", freq8, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    nv = 0;
    nb = 0;
    repeat (1100) begin tick(); if (valid) nv++; if (busy) nb++; end
    chk("post_rst_valid", nv, 0);
    chk("post_rst_busy", nb, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
